// File: rtl/fetch_buffer_if.sv
// Fetch buffer bus: instruction-memory read port, execute redirect, and the decode-facing head.
// master is the fetch buffer side; slave is the memory/decode/execute environment.
interface fetch_buffer_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_rdata;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        i_instr_ready;
  logic        o_illegal;

  modport master (
    output o_imem_req, o_imem_addr, o_instr_valid, o_instr, o_pc, o_illegal,
    input  i_imem_rdata, i_redirect, i_redirect_pc, i_instr_ready
  );

  modport slave (
    input  o_imem_req, o_imem_addr, o_instr_valid, o_instr, o_pc, o_illegal,
    output i_imem_rdata, i_redirect, i_redirect_pc, i_instr_ready
  );
endinterface

// File: rtl/fetch_buffer.sv
// Fetch stage: owns the fetch PC, issues 1-cycle imem reads, queues words+PCs for decode.
// Latency: 2 cycles from request to o_instr_valid (no bypass); redirect flushes in 1 cycle.
// Backpressure: credit count (entries + in-flight) stops requests at DEPTH; FETCH_BUF_OPCODE_CHECK_EN adds o_illegal.
module fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  fetch_buffer_if.master bus
);
  localparam int          AW  = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] inflight_pc;
  logic        inflight;
  logic [AW:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  logic          req;
  logic          push;
  logic          pop;
  logic          valid;
  logic [AW+1:0] credits;
  logic [1:0]    unused_pc_lsb;

  assign unused_pc_lsb = bus.i_redirect_pc[1:0];

  // Pops are deliberately not credited until the count register reflects them.
  assign credits = {1'b0, count} + {{(AW+1){1'b0}}, inflight};
  assign req     = !i_rst && !bus.i_redirect && (credits < (AW+2)'(DEPTH));
  assign valid   = (count != '0);
  assign pop     = valid && bus.i_instr_ready;
  // A response is only ever outstanding in RUN; the redirect cycle discards it.
  assign push    = inflight && (state == RUN) && !bus.i_redirect;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (bus.i_redirect) begin
      state    <= FLUSH;
      fetch_pc <= {bus.i_redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      state    <= RUN;
      inflight <= req;
      if (req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= bus.i_imem_rdata;
      pc_mem[wr_ptr]    <= inflight_pc;
    end
  end

  assign bus.o_imem_req    = req;
  assign bus.o_imem_addr   = fetch_pc;
  assign bus.o_instr_valid = valid;
  assign bus.o_instr       = valid ? instr_mem[rd_ptr] : NOP;
  assign bus.o_pc          = valid ? pc_mem[rd_ptr] : 32'h0;

`ifdef FETCH_BUF_OPCODE_CHECK_EN
  logic [DEPTH-1:0] ill_mem;
  logic             rdata_ill;

  // Classified once on arrival so decode sees a registered flag with the word.
  assign rdata_ill = (bus.i_imem_rdata[1:0] != 2'b11) || (bus.i_imem_rdata == 32'h0);

  always_ff @(posedge i_clk) begin
    if (push) ill_mem[wr_ptr] <= rdata_ill;
  end

  assign bus.o_illegal = valid && ill_mem[rd_ptr];
`else
  assign bus.o_illegal = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_buffer.sv
`timescale 1ns/1ps
module tb_fetch_buffer;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_BUF_OPCODE_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  fetch_buffer_if bus ();

  fetch_buffer #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory: answers the address seen at the previous edge.
  logic        mem_mode = 1'b0;
  logic [31:0] rd_addr_q = 32'h0;

  function automatic logic [31:0] memf(input logic [31:0] a, input logic mode);
    if (mode) return a[2] ? 32'h0000_0013 : 32'h0000_0001;
    return a ^ 32'hA5A5_0000;
  endfunction

  always @(posedge i_clk) rd_addr_q <= bus.o_imem_addr;
  assign bus.i_imem_rdata = memf(rd_addr_q, mem_mode);

  // Reference model: a queue of delivered-to-be words and one pending fetch.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic        m_pend_v  = 1'b0;
  logic [31:0] m_pend_pc = 32'h0;
  logic [31:0] m_pc      = RESET_PC;

  always @(negedge i_clk) begin
    logic        e_req, e_valid, e_ill;
    logic [31:0] e_instr, e_pc;
    if (i_rst) begin
      mq.delete();
      m_pend_v = 1'b0;
      m_pc     = RESET_PC;
    end
    e_req   = !i_rst && !bus.i_redirect && ((mq.size() + (m_pend_v ? 1 : 0)) < DEPTH);
    e_valid = (mq.size() != 0);
    e_instr = e_valid ? mq[0].instr : NOP;
    e_pc    = e_valid ? mq[0].pc : 32'h0;
    e_ill   = CHK_EN && e_valid && ((e_instr[1:0] != 2'b11) || (e_instr == 32'h0));
    chk1("imem_req",    bus.o_imem_req,    e_req);
    chk ("imem_addr",   bus.o_imem_addr,   m_pc);
    chk1("instr_valid", bus.o_instr_valid, e_valid);
    chk ("instr",       bus.o_instr,       e_instr);
    chk ("pc",          bus.o_pc,          e_pc);
    chk1("illegal",     bus.o_illegal,     e_ill);
    if (!i_rst) begin
      if (bus.i_redirect) begin
        mq.delete();
        m_pend_v = 1'b0;
        m_pc     = {bus.i_redirect_pc[31:2], 2'b00};
      end else begin
        if (e_valid && bus.i_instr_ready) void'(mq.pop_front());
        if (m_pend_v) mq.push_back('{pc: m_pend_pc, instr: memf(m_pend_pc, mem_mode)});
        m_pend_v = e_req;
        if (e_req) begin
          m_pend_pc = m_pc;
          m_pc      = m_pc + 32'd4;
        end
      end
    end
  end

  // Drive inputs 1ns after the edge; return 3ns after the edge for directed sampling.
  task automatic cyc(input logic rdy, input logic redir, input logic [31:0] rpc);
    @(posedge i_clk);
    #1;
    bus.i_instr_ready = rdy;
    bus.i_redirect    = redir;
    bus.i_redirect_pc = rpc;
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] issued[$];
    logic [31:0] deliv[$];
    int          n_req;
    int          first_valid;
    bit          found;

    bus.i_instr_ready = 1'b0;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = 32'h0;
    repeat (3) cyc(1'b0, 1'b0, 32'h0);
    chk1("reset_valid", bus.o_instr_valid, 1'b0);
    chk1("reset_req",   bus.o_imem_req,    1'b0);
    chk ("reset_instr", bus.o_instr,       NOP);

    // Stall from reset: exactly DEPTH requests, head frozen on 0x100.
    n_req = 0;
    first_valid = -1;
    for (int c = 0; c < 10; c++) begin
      if (c == 0) begin
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        #2;
        chk("first_addr", bus.o_imem_addr, 32'h0000_0100);
      end else begin
        cyc(1'b0, 1'b0, 32'h0);
      end
      if (bus.o_imem_req) begin
        n_req++;
        issued.push_back(bus.o_imem_addr);
      end
      if (bus.o_instr_valid && first_valid < 0) first_valid = c;
    end
    chk("stall_req_count", n_req, DEPTH);
    chk("first_valid_cycle", first_valid, 2);
    chk1("stall_req_low", bus.o_imem_req, 1'b0);
    chk("stall_head_pc", bus.o_pc, 32'h0000_0100);
    chk("stall_head_instr", bus.o_instr, 32'hA5A5_0100);

    // Release: in-order delivery, fetch continues at 0x108.
    for (int c = 0; c < 8; c++) begin
      cyc(1'b1, 1'b0, 32'h0);
      if (bus.o_instr_valid) deliv.push_back(bus.o_pc);
      if (bus.o_imem_req) issued.push_back(bus.o_imem_addr);
    end
    chk("deliv0", deliv[0], 32'h0000_0100);
    chk("deliv1", deliv[1], 32'h0000_0104);
    chk("deliv2", deliv[2], 32'h0000_0108);
    chk("issued0", issued[0], 32'h0000_0100);
    chk("issued1", issued[1], 32'h0000_0104);
    chk("issued2", issued[2], 32'h0000_0108);

    // Redirect while one word is buffered and another is in flight.
    cyc(1'b0, 1'b1, 32'h0000_3000);
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h0000_2002);
    chk1("pre_redirect_valid", bus.o_instr_valid, 1'b1);
    cyc(1'b0, 1'b0, 32'h0);
    chk1("post_redirect_valid", bus.o_instr_valid, 1'b0);
    chk1("post_redirect_req", bus.o_imem_req, 1'b1);
    chk("post_redirect_addr", bus.o_imem_addr, 32'h0000_2000);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      cyc(1'b1, 1'b0, 32'h0);
      if (bus.o_instr_valid) begin
        found = 1'b1;
        chk("redirect_first_pc", bus.o_pc, 32'h0000_2000);
        chk("redirect_first_instr", bus.o_instr, 32'hA5A5_2000);
      end
    end
    chk1("redirect_delivered", found, 1'b1);

    // PC wrap.
    cyc(1'b1, 1'b1, 32'hFFFF_FFFE);
    cyc(1'b1, 1'b0, 32'h0);
    chk("wrap_addr0", bus.o_imem_addr, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0);
    chk("wrap_addr1", bus.o_imem_addr, 32'h0000_0000);

    // Opcode check words: 0x1 then 0x13.
    cyc(1'b0, 1'b1, 32'h0000_0000);
    mem_mode = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      cyc(1'b0, 1'b0, 32'h0);
      if (bus.o_instr_valid) found = 1'b1;
    end
    chk1("opc_first_found", found, 1'b1);
    chk("opc_first_instr", bus.o_instr, 32'h0000_0001);
    chk1("opc_first_illegal", bus.o_illegal, CHK_EN);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("opc_second_instr", bus.o_instr, 32'h0000_0013);
    chk("opc_second_pc", bus.o_pc, 32'h0000_0004);
    chk1("opc_second_illegal", bus.o_illegal, 1'b0);

    // Randomized traffic with an asynchronous reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      cyc(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < 6) ? 1'b1 : 1'b0,
          $urandom);
      if (c % 500 == 499) mem_mode = ~mem_mode;
      if (c == 1500) begin
        i_rst = 1'b1;
        #1;
        chk1("arst_valid", bus.o_instr_valid, 1'b0);
        chk1("arst_req", bus.o_imem_req, 1'b0);
        chk ("arst_instr", bus.o_instr, NOP);
        chk ("arst_pc", bus.o_pc, 32'h0);
        chk ("arst_addr", bus.o_imem_addr, RESET_PC);
        chk1("arst_illegal", bus.o_illegal, 1'b0);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        i_rst = 1'b0;
        #1;
        chk1("post_arst_req", bus.o_imem_req, 1'b1);
        chk ("post_arst_addr", bus.o_imem_addr, RESET_PC);
      end
    end

    cyc(1'b1, 1'b0, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
